// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter sharing one 4:1 data mux, up to MAX_BEATS beats per grant
module mux4_rr_arbiter #(
    parameter int DW        = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] din,
    output logic [3:0]      gnt,
    output logic [1:0]      sel,
    output logic            busy,
    output logic [DW-1:0]   dout,
    output logic            dout_vld
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic [7:0] MAX_B = 8'(MAX_BEATS);
    state_t          state_q, state_d;
    logic [3:0]      gnt_q, gnt_d;
    logic [1:0]      sel_q, sel_d;
    logic            busy_q, busy_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic            dout_vld_q, dout_vld_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;
    logic [1:0]      last_ptr_q, last_ptr_d;
    logic [1:0]      win;
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        beat_cnt_d = beat_cnt_q;
        last_ptr_d = last_ptr_q;
        win        = last_ptr_q;
        for (int k = 3; k >= 0; k--)
            if (req[last_ptr_q + 2'(k + 1)]) win = last_ptr_q + 2'(k + 1);
        if (state_q == IDLE) begin
            gnt_d  = '0;
            busy_d = 1'b0;
            if (|req) begin
                state_d    = GRANT;
                gnt_d      = 4'b1 << win;
                sel_d      = win;
                busy_d     = 1'b1;
                last_ptr_d = win;
                beat_cnt_d = '0;
            end
        end else begin
            if (req[sel_q] && beat_cnt_q < MAX_B) begin
                dout_d     = din[sel_q*DW +: DW];
                dout_vld_d = 1'b1;
                beat_cnt_d = beat_cnt_q + 8'd1;
            end
            if (!req[sel_q] || beat_cnt_d == MAX_B) begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            busy_q     <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            beat_cnt_q <= '0;
            last_ptr_q <= 2'd3;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            beat_cnt_q <= beat_cnt_d;
            last_ptr_q <= last_ptr_d;
        end
    end
    assign gnt      = gnt_q;
    assign sel      = sel_q;
    assign busy     = busy_q;
    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed stimulus with a queue scoreboard checked by a beat monitor
module tb_mux4_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        busy;
    logic [7:0]  dout;
    logic        dout_vld;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  expq[$];
    logic [3:0]  e;

    mux4_rr_arbiter #(.DW(8), .MAX_BEATS(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din),
        .gnt(gnt), .sel(sel), .busy(busy), .dout(dout), .dout_vld(dout_vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'h0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (dout_vld === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat got %0h want no beat", dout);
            end else begin
                check("beat", 32'(dout), 32'(expq.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'hF;
        din   = '0;
        step();
        step();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_vld", 32'(dout_vld), 0);
        check("rst_sel", 32'(sel), 0);
        check("rst_dout", 32'(dout), 0);
        rst_n = 1'b1;
        step();
        check("rel_gnt", 32'(gnt), 32'h1);

        do_reset();
        expq.push_back(8'hA0); expq.push_back(8'hA1);
        expq.push_back(8'hA2); expq.push_back(8'hA3);
        req = 4'b0100;
        step();
        check("single_gnt", 32'(gnt), 32'h4);
        check("single_sel", 32'(sel), 2);
        check("single_busy", 32'(busy), 1);
        for (int b = 0; b < 4; b++) begin
            din[16 +: 8] = 8'hA0 + 8'(b);
            step();
        end
        check("single_end_gnt", 32'(gnt), 0);
        check("single_end_busy", 32'(busy), 0);
        din[16 +: 8] = 8'hA4;
        step();
        check("single_regnt", 32'(gnt), 32'h4);
        check("single_hold_vld", 32'(dout_vld), 0);
        check("single_hold_dout", 32'(dout), 32'hA3);

        do_reset();
        din = 32'h44332211;
        for (int g = 0; g < 5; g++)
            for (int b = 0; b < 4; b++) expq.push_back(8'h11 * 8'(g % 4 + 1));
        req = 4'hF;
        for (int n = 1; n <= 25; n++) begin
            step();
            e = 4'b1 << ((n / 5) % 4);
            if (n % 5 == 1) check("fair_gnt", 32'(gnt), 32'(e));
            if (n % 5 == 0) check("fair_gap", 32'(gnt), 0);
        end
        req = 4'h0;
        step();
        step();
        check("fair_idle_busy", 32'(busy), 0);

        do_reset();
        din = 32'h66000055;
        expq.push_back(8'h55); expq.push_back(8'h55);
        req = 4'b1001;
        step();
        check("early_gnt0", 32'(gnt), 32'h1);
        step();
        step();
        req = 4'b1000;
        step();
        check("early_busy", 32'(busy), 0);
        check("early_gap", 32'(gnt), 0);
        step();
        check("early_gnt3", 32'(gnt), 32'h8);

        do_reset();
        din = 32'h99000077;
        for (int b = 0; b < 4; b++) expq.push_back(8'h77);
        req = 4'b1001;
        step();
        check("wrap_gnt0", 32'(gnt), 32'h1);
        for (int b = 0; b < 4; b++) step();
        step();
        check("wrap_gnt3", 32'(gnt), 32'h8);
        check("wrap_sel3", 32'(sel), 3);

        do_reset();
        din = 32'h00008800;
        expq.push_back(8'h88);
        req = 4'b0010;
        step();
        check("mid_gnt1", 32'(gnt), 32'h2);
        step();
        rst_n = 1'b0;
        step();
        check("mid_gnt", 32'(gnt), 0);
        check("mid_busy", 32'(busy), 0);
        check("mid_vld", 32'(dout_vld), 0);
        check("mid_sel", 32'(sel), 0);
        check("mid_dout", 32'(dout), 0);
        rst_n = 1'b1;
        req = 4'b0011;
        step();
        check("mid_regnt", 32'(gnt), 32'h1);
        rst_n = 1'b0;
        req = 4'h0;
        step();
        step();
        check("queue_empty", 32'(expq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
